// File: rtl/wb_stage_regfile.sv
// MEM/WB pipeline latch feeding a register file with two combinational read ports.
// The latched writeback triple is exported for forwarding and hazard detection,
// and a free-running counter tracks how many register-file commits have occurred.
// Optional macro WB_BYPASS_EN: read ports return the in-flight commit value
// (write-before-read); when undefined, reads return array contents only.
module wb_stage_regfile #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_in,
   input  logic [DATA_W-1:0] ALU_result_in,
   input  logic [ADDR_W-1:0] dst_addr_in,
   input  logic [ADDR_W-1:0] rs_addr,
   input  logic [ADDR_W-1:0] rt_addr,
   output logic [DATA_W-1:0] rs_data,
   output logic [DATA_W-1:0] rt_data,
   output logic              wb_valid_out,
   output logic [DATA_W-1:0] wb_data_out,
   output logic [ADDR_W-1:0] wb_dst_out,
   output logic [CNT_W-1:0]  commit_cnt
);

   localparam int unsigned NUM_REGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              commit;

   // Writes to r0 are dropped, so they neither update the array nor count.
   assign commit = wb_valid_out && (wb_dst_out != '0);

   // MEM/WB latch: captures the EX/MEM triple every cycle, no stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_out <= 1'b0;
         wb_data_out  <= '0;
         wb_dst_out   <= '0;
      end else begin
         wb_valid_out <= wb_in;
         wb_data_out  <= ALU_result_in;
         wb_dst_out   <= dst_addr_in;
      end
   end

   // Register file commit from the latched triple; reset discards any pending triple.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '{default: '0};
      end else if (commit) begin
         regs[wb_dst_out] <= wb_data_out;
      end
   end

   // Commit counter, wraps naturally at 2**CNT_W.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         commit_cnt <= '0;
      end else if (commit) begin
         commit_cnt <= commit_cnt + 1'b1;
      end
   end

   // Combinational read ports; r0 is forced to zero regardless of array contents.
   always_comb begin
      rs_data = regs[rs_addr];
      rt_data = regs[rt_addr];
`ifdef WB_BYPASS_EN
      if (commit && (wb_dst_out == rs_addr)) rs_data = wb_data_out;
      if (commit && (wb_dst_out == rt_addr)) rt_data = wb_data_out;
`endif
      if (rs_addr == '0) rs_data = '0;
      if (rt_addr == '0) rt_data = '0;
   end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Scoreboard bench for wb_stage_regfile: issued writeback triples are queued and a
// negedge monitor pops and compares them whenever the MEM/WB latch shows valid.
// Reads and commit counts are checked against hand-computed directed values.
module tb_wb_stage_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_in;
   logic [31:0] alu;
   logic [4:0]  dst;
   logic [4:0]  rs_addr;
   logic [4:0]  rt_addr;

   logic [31:0] rs_data, rt_data, wb_data_out;
   logic        wb_valid_out;
   logic [4:0]  wb_dst_out;
   logic [15:0] commit_cnt;

   logic [31:0] rs_data_n, rt_data_n, wb_data_out_n;
   logic        wb_valid_out_n;
   logic [4:0]  wb_dst_out_n;
   logic [3:0]  commit_cnt_n;

   int checks   = 0;
   int failures = 0;
   int exp_cnt  = 0;

   logic [36:0] exp_q [$];

   always #5 clk = ~clk;

   wb_stage_regfile dut (
      .clk(clk), .rst(rst), .wb_in(wb_in), .ALU_result_in(alu), .dst_addr_in(dst),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
      .wb_valid_out(wb_valid_out), .wb_data_out(wb_data_out), .wb_dst_out(wb_dst_out),
      .commit_cnt(commit_cnt)
   );

   wb_stage_regfile #(.CNT_W(4)) dut_n (
      .clk(clk), .rst(rst), .wb_in(wb_in), .ALU_result_in(alu), .dst_addr_in(dst),
      .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data_n), .rt_data(rt_data_n),
      .wb_valid_out(wb_valid_out_n), .wb_data_out(wb_data_out_n),
      .wb_dst_out(wb_dst_out_n), .commit_cnt(commit_cnt_n)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic check_cnt(input string name);
      check({name, "_cnt16"}, {16'h0, commit_cnt}, exp_cnt & 32'hffff);
      check({name, "_cnt4"}, {28'h0, commit_cnt_n}, exp_cnt & 32'hf);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] d, input logic [31:0] v);
      wb_in = 1'b1;
      dst   = d;
      alu   = v;
      exp_q.push_back({d, v});
   endtask

   task automatic idle();
      wb_in = 1'b0;
      dst   = '0;
      alu   = '0;
   endtask

   // Monitor: pop and compare whenever the latched triple is presented as valid.
   always @(negedge clk) begin
      if (!rst && wb_valid_out) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb: got dst %0d data %h expected none",
                     wb_dst_out, wb_data_out);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("wb_dst", {27'h0, wb_dst_out}, {27'h0, e[36:32]});
            check("wb_data", wb_data_out, e[31:0]);
         end
      end
   end

   initial begin
      logic [31:0] inflight_exp;
      rst = 1'b1;
      idle();
      rs_addr = '0;
      rt_addr = '0;
      step();
      step();
      rst = 1'b0;
      #1;
      check("reset_valid", {31'h0, wb_valid_out}, 32'h0);
      check("reset_data", wb_data_out, 32'h0);
      check_cnt("reset");

      // r5 = 0x1234, then reset mid-stream with r6 pending in MEM/WB
      issue(5'd5, 32'h1234);
      step();
      issue(5'd6, 32'h77);
      step();
      exp_cnt = 1;
      idle();
      rs_addr = 5'd5;
      #1;
      check("r5_before_reset", rs_data, 32'h1234);
      #4;                               // past the monitor's negedge
      rst = 1'b1;
      #1;
      check("async_valid", {31'h0, wb_valid_out}, 32'h0);
      check("async_data", wb_data_out, 32'h0);
      check("async_dst", {27'h0, wb_dst_out}, 32'h0);
      exp_cnt = 0;
      check_cnt("async");
      check("async_r5", rs_data, 32'h0);
      step();
      rst = 1'b0;
      step();
      rs_addr = 5'd6;
      #1;
      check("discarded_r6", rs_data, 32'h0);
      check_cnt("discarded");

      // Basic latency
      issue(5'd3, 32'hDEADBEEF);
      step();
      check("lat_valid", {31'h0, wb_valid_out}, 32'h1);
      check("lat_dst", {27'h0, wb_dst_out}, 32'd3);
      idle();
      rs_addr = 5'd3;
      #1;
`ifdef WB_BYPASS_EN
      check("lat_inflight", rs_data, 32'hDEADBEEF);
`else
      check("lat_inflight", rs_data, 32'h0);
`endif
      step();
      exp_cnt = 1;
      check("lat_r3", rs_data, 32'hDEADBEEF);
      check_cnt("lat");

      // r0 protection
      issue(5'd0, 32'hFFFFFFFF);
      step();
      idle();
      rs_addr = 5'd0;
      rt_addr = 5'd0;
      #1;
      check("r0_inflight", rs_data, 32'h0);
      step();
      check("r0_rs", rs_data, 32'h0);
      check("r0_rt", rt_data, 32'h0);
      check_cnt("r0");

      // Back-to-back r7 = 1, 2, 3
      rs_addr = 5'd7;
      issue(5'd7, 32'd1);
      step();
      issue(5'd7, 32'd2);
      step();
      issue(5'd7, 32'd3);
      #1;
`ifdef WB_BYPASS_EN
      inflight_exp = 32'd2;
`else
      inflight_exp = 32'd1;
`endif
      check("b2b_first", rs_data, inflight_exp);
      step();
      idle();
      #1;
`ifdef WB_BYPASS_EN
      inflight_exp = 32'd3;
`else
      inflight_exp = 32'd2;
`endif
      check("b2b_second", rs_data, inflight_exp);
      step();
      exp_cnt = 4;
      check("b2b_final", rs_data, 32'd3);
      check_cnt("b2b");

      // Bypass window on both ports
      issue(5'd9, 32'h55);
      step();
      idle();
      rs_addr = 5'd9;
      rt_addr = 5'd9;
      #1;
`ifdef WB_BYPASS_EN
      inflight_exp = 32'h55;
`else
      inflight_exp = 32'h0;
`endif
      check("bypass_rs", rs_data, inflight_exp);
      check("bypass_rt", rt_data, inflight_exp);
      rt_addr = 5'd7;
      step();
      exp_cnt = 5;
      check("bypass_rs_after", rs_data, 32'h55);
      check("ports_differ_rt", rt_data, 32'd3);
      check_cnt("bypass");

      // Counter wrap: fresh reset, then 17 non-zero commits
      rst = 1'b1;
      #1;
      exp_cnt = 0;
      step();
      rst = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         issue(i[4:0], 32'h100 + i);
         step();
      end
      idle();
      step();
      exp_cnt = 17;
      check_cnt("wrap");
      rs_addr = 5'd17;
      rt_addr = 5'd1;
      #1;
      check("wrap_r17", rs_data, 32'h111);
      check("wrap_r1", rt_data, 32'h101);

      step();
      check("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
